// File: rtl/reg_file_param.sv
// Parametrised 16-bit register file: two combinational read ports, one write port,
// built-in stack pointer with sticky wrap flag. Optional forwarding: REG_FILE_BYPASS_EN.
module reg_file_param #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 4,
   parameter int                NUM_REGS = 13,
   parameter int                SP_INDEX = 12,
   parameter logic [DATA_W-1:0] SP_RESET = 16'h03FF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [1:0]        sp_op,
   output logic [DATA_W-1:0] sp_value,
   output logic              sp_wrap,
   input  logic              sp_wrap_clr
);

   if (NUM_REGS > 2**ADDR_W || SP_INDEX < 1 || SP_INDEX >= NUM_REGS) begin : g_param_err
      $error("reg_file_param: illegal NUM_REGS/SP_INDEX for ADDR_W");
   end

   localparam logic [1:0] SP_PUSH = 2'b01;
   localparam logic [1:0] SP_POP  = 2'b10;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              sp_wrap_q, sp_wrap_d;
   logic [DATA_W-1:0] sp_cur;
   logic              wr_sp;
   logic [DATA_W-1:0] rd_src [NUM_REGS];

   always_comb begin
      regs_d    = regs_q;
      sp_cur    = regs_q[SP_INDEX];
      wr_sp     = wr_en && (wr_addr == ADDR_W'(SP_INDEX));
      sp_wrap_d = sp_wrap_q & ~sp_wrap_clr;
      // An explicit write to SP discards the stack op, including its wrap effect.
      if (!wr_sp) begin
         if (sp_op == SP_PUSH) begin
            regs_d[SP_INDEX] = sp_cur - DATA_W'(1);
            if (sp_cur == '0) sp_wrap_d = 1'b1;
         end else if (sp_op == SP_POP) begin
            regs_d[SP_INDEX] = sp_cur + DATA_W'(1);
            if (sp_cur == '1) sp_wrap_d = 1'b1;
         end
      end
      for (int i = 1; i < NUM_REGS; i++) begin
         if (wr_en && (wr_addr == ADDR_W'(i))) regs_d[i] = wr_data;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
         end
         sp_wrap_q <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         sp_wrap_q <= sp_wrap_d;
      end
   end

`ifdef REG_FILE_BYPASS_EN
   // Forward next-state contents; held off during reset so reads show reset values.
   always_comb begin
      rd_src = reset ? regs_q : regs_d;
   end
`else
   always_comb begin
      rd_src = regs_q;
   end
`endif

   // Out-of-range addresses match no entry and read zero.
   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr_a == ADDR_W'(i)) rd_data_a = rd_src[i];
         if (rd_addr_b == ADDR_W'(i)) rd_data_b = rd_src[i];
      end
   end

   assign sp_value = regs_q[SP_INDEX];
   assign sp_wrap  = sp_wrap_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param with default parameters.
module tb_reg_file_param;

   logic        clk;
   logic        reset;
   logic [3:0]  rd_addr_a, rd_addr_b, wr_addr;
   logic [15:0] rd_data_a, rd_data_b, wr_data, sp_value;
   logic        wr_en, sp_wrap, sp_wrap_clr;
   logic [1:0]  sp_op;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] sb_q [$];

   reg_file_param dut (
      .clk         (clk),
      .reset       (reset),
      .rd_addr_a   (rd_addr_a),
      .rd_addr_b   (rd_addr_b),
      .rd_data_a   (rd_data_a),
      .rd_data_b   (rd_data_b),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .sp_op       (sp_op),
      .sp_value    (sp_value),
      .sp_wrap     (sp_wrap),
      .sp_wrap_clr (sp_wrap_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input logic [15:0] exp);
      sb_q.push_back(exp);
   endtask

   task automatic sb_pop(input string tag, input logic [15:0] obs);
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %h", tag, obs);
      end else begin
         chk(tag, obs, sb_q.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr_a = '0; rd_addr_b = '0; sp_op = 2'b00; sp_wrap_clr = 1'b0;
      #2;
      for (int a = 0; a < 16; a++) begin
         rd_addr_a = 4'(a);
         rd_addr_b = 4'(15 - a);
         sb_push((a == 12) ? 16'h03FF : 16'h0000);
         sb_push(((15 - a) == 12) ? 16'h03FF : 16'h0000);
         #1;
         sb_pop("rst_rd_a", rd_data_a);
         sb_pop("rst_rd_b", rd_data_b);
      end
      sb_push(16'h03FF); sb_pop("rst_sp_value", sp_value);
      sb_push(16'h0000); sb_pop("rst_sp_wrap", {15'b0, sp_wrap});
      reset = 1'b0;

      write_reg(4'd3, 16'hBEEF);
      write_reg(4'd0, 16'h1234);
      write_reg(4'd14, 16'h1234);
      rd_addr_a = 4'd3; rd_addr_b = 4'd0;
      sb_push(16'hBEEF); sb_push(16'h0000);
      #1;
      sb_pop("wr_reg3", rd_data_a);
      sb_pop("wr_reg0", rd_data_b);
      rd_addr_b = 4'd14; rd_addr_a = 4'd13;
      sb_push(16'h0000); sb_push(16'h0000);
      #1;
      sb_pop("wr_addr14", rd_data_b);
      sb_pop("rd_addr13", rd_data_a);

      write_reg(4'd12, 16'h0001);
      sb_push(16'h0001); sb_pop("sp_load", sp_value);
      sp_op = 2'b01;
      tick();
      sb_push(16'h0000); sb_pop("push1_sp", sp_value);
      sb_push(16'h0000); sb_pop("push1_wrap", {15'b0, sp_wrap});
      tick();
      sb_push(16'hFFFF); sb_pop("push2_sp", sp_value);
      sb_push(16'h0001); sb_pop("push2_wrap", {15'b0, sp_wrap});
      rd_addr_a = 4'd12;
      sb_push(16'hFFFF); #1; sb_pop("sp_read_match", rd_data_a);
      sp_op = 2'b10;
      tick();
      sb_push(16'h0000); sb_pop("pop_sp", sp_value);
      sb_push(16'h0001); sb_pop("pop_wrap", {15'b0, sp_wrap});
      sp_op = 2'b00; sp_wrap_clr = 1'b1;
      tick();
      sb_push(16'h0000); sb_pop("clr_wrap", {15'b0, sp_wrap});
      sb_push(16'h0000); sb_pop("clr_sp_hold", sp_value);
      sp_op = 2'b01;
      tick();
      sp_op = 2'b00; sp_wrap_clr = 1'b0;
      sb_push(16'hFFFF); sb_pop("setclr_sp", sp_value);
      sb_push(16'h0001); sb_pop("setclr_wrap", {15'b0, sp_wrap});

      sp_op = 2'b01;
      write_reg(4'd12, 16'h0100);
      sp_op = 2'b00;
      sb_push(16'h0100); sb_pop("coll_push_sp", sp_value);
      sb_push(16'h0001); sb_pop("coll_push_wrap", {15'b0, sp_wrap});
      sp_wrap_clr = 1'b1;
      tick();
      sp_wrap_clr = 1'b0;
      write_reg(4'd12, 16'hFFFF);
      sp_op = 2'b10;
      write_reg(4'd12, 16'h0200);
      sp_op = 2'b00;
      sb_push(16'h0200); sb_pop("coll_pop_sp", sp_value);
      sb_push(16'h0000); sb_pop("coll_pop_wrap", {15'b0, sp_wrap});

      write_reg(4'd5, 16'h1111);
      rd_addr_a = 4'd5;
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h5555;
`ifdef REG_FILE_BYPASS_EN
      sb_push(16'h5555);
`else
      sb_push(16'h1111);
`endif
      #1;
      sb_pop("byp_same_cycle", rd_data_a);
      tick();
      wr_en = 1'b0;
      sb_push(16'h5555); sb_pop("byp_after_edge", rd_data_a);

      rd_addr_b = 4'd12; sp_op = 2'b01;
`ifdef REG_FILE_BYPASS_EN
      sb_push(16'h01FF);
`else
      sb_push(16'h0200);
`endif
      #1;
      sb_pop("byp_sp_read", rd_data_b);
      sb_push(16'h0200); sb_pop("byp_sp_value", sp_value);
      tick();
      sp_op = 2'b00;
      sb_push(16'h01FF); sb_pop("sp_after_push", rd_data_b);

      write_reg(4'd12, 16'hFFFF);
      sp_op = 2'b10;
      tick();
      sp_op = 2'b00;
      sb_push(16'h0001); sb_pop("prerst_wrap", {15'b0, sp_wrap});
      rd_addr_a = 4'd3;
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hAAAA; sp_op = 2'b10;
      #3;
      reset = 1'b1;
      #1;
      sb_push(16'h03FF); sb_pop("arst_sp_value", sp_value);
      sb_push(16'h0000); sb_pop("arst_wrap", {15'b0, sp_wrap});
      sb_push(16'h0000); sb_pop("arst_rd_reg3", rd_data_a);
      sb_push(16'h03FF); sb_pop("arst_rd_sp", rd_data_b);
      tick();
      wr_en = 1'b0; sp_op = 2'b00;
      reset = 1'b0;
      tick();
      sb_push(16'h0000); sb_pop("post_rst_reg3", rd_data_a);
      sb_push(16'h03FF); sb_pop("post_rst_sp", sp_value);
      sb_push(16'h0000); sb_pop("post_rst_wrap", {15'b0, sp_wrap});

      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_leftover: %0d entries, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: run exceeded 50000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised general-purpose register file for the 16-bit datapath; successor to the fixed 12-register bank.
- Two independent combinational read ports and one dedicated write port with its own address, so reads no longer share an address with the write.
- Built-in stack-pointer register with push/pop arithmetic and a sticky wrap flag.
- Sits between instruction decode (addresses, stack ops) and the ALU/writeback stage.

Parameters:
- DATA_W, 16, width of every register and data port.
- ADDR_W, 4, width of all register address ports.
- NUM_REGS, 13, number of implemented registers (indices 0..NUM_REGS-1), NUM_REGS <= 2**ADDR_W.
- SP_INDEX, 12, index of the stack-pointer register, 1 <= SP_INDEX < NUM_REGS.
- SP_RESET, 16'h03FF, reset value of the stack pointer, DATA_W bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_a  output  DATA_W  read port A data (combinational).
- rd_data_b  output  DATA_W  read port B data (combinational).
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- sp_op  input  2  stack op: 00 none, 01 push, 10 pop, 11 reserved (no-op).
- sp_value  output  DATA_W  current stack-pointer contents (registered).
- sp_wrap  output  1  sticky flag, set when a push/pop wraps modulo 2**DATA_W.
- sp_wrap_clr  input  1  synchronous clear of sp_wrap.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - every register is 0, except register SP_INDEX, which is SP_RESET;
  - sp_wrap is 0;
  - rd_data_a and rd_data_b show the reset contents of the addressed registers.
- Register 0 is hardwired to zero: it always reads 0 and writes to it are ignored.
- Addresses >= NUM_REGS read 0, and writes to them are ignored (no aliasing).
- Reads are combinational from the current register contents, with zero cycles of latency. Without the bypass feature, a value written at edge N is visible on the read ports after edge N.
- A write takes effect at the rising edge when wr_en=1, storing wr_data into wr_addr.
- Stack ops are evaluated on each rising edge:
  - push: sp <= sp - 1;
  - pop: sp <= sp + 1;
  - arithmetic is unsigned and modulo 2**DATA_W.
- Wrap detection:
  - a push with sp=0 yields all-ones and sets sp_wrap;
  - a pop with sp=all-ones yields 0 and sets sp_wrap.
- sp_wrap stays set until reset or sp_wrap_clr=1 at an edge. If a clear and a new wrap occur on the same edge, the set wins and the flag stays 1.
- Collision: if wr_en=1, wr_addr=SP_INDEX and sp_op is push or pop on the same edge, the explicit write wins. The stack op is discarded and sp_wrap is unchanged.
- sp_value always equals the stored SP register and matches what a read of SP_INDEX returns.
- Reset asserted mid-cycle overrides any pending write or stack op; nothing is committed.
- Elaboration fails (generate-time error) if NUM_REGS > 2**ADDR_W or if SP_INDEX is 0 or >= NUM_REGS.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding. When wr_en=1 and wr_addr equals a port's read address (nonzero and < NUM_REGS), that port returns wr_data in the same cycle.
  - A forwarded stack op also applies to reads of SP_INDEX: those return the post-op value in the same cycle, with the explicit write taking priority as above.
  - sp_value is not forwarded.
- Undefined: no forwarding. Reads return stored contents only, and new values appear the cycle after the edge.

Test Plan:
- Reset with the default parameters: every read address returns 0, except address 12, which returns 16'h03FF; sp_value=16'h03FF and sp_wrap=0.
- Write 16'hBEEF to reg 3, then 16'h1234 to reg 0 and to address 14:
  - port A reads 16'hBEEF at reg 3;
  - port B reads 0 at reg 0 and 0 at address 14.
- With SP=16'h0001, push twice:
  - sp_value goes 16'h0000, then 16'hFFFF;
  - sp_wrap rises after the second edge;
  - pop once gives 16'h0000 and sets sp_wrap again;
  - sp_wrap_clr=1 for one edge with sp_op=00 clears sp_wrap to 0.
- On the same edge, wr_en=1, wr_addr=12, wr_data=16'h0100 and sp_op=push: sp_value=16'h0100 and sp_wrap is unchanged.
- Write 16'h5555 to reg 5 while rd_addr_a=5:
  - without the macro, rd_data_a shows the old value until the edge and 16'h5555 after it;
  - with REG_FILE_BYPASS_EN, rd_data_a shows 16'h5555 in the same cycle.
- Assert reset asynchronously between edges while wr_en=1 and sp_op=pop: all outputs go to their reset values immediately, and no write or pop is committed.
